// File: rtl/counter_bank.sv
// ============================================================================
// Module      : counter_bank
// Description : N_CH independent counters. Each channel has a prescaler,
//               manual up/down steps, auto-count direction, wrap/saturate mode,
//               compare/zero flags and terminal-count pulses.
//               Optional snapshot bank enabled by COUNTER_BANK_SNAPSHOT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module counter_bank #(
  parameter int N_CH      = 2,
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 24
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic [N_CH-1:0]           ch_clear,
  input  logic [N_CH-1:0]           ch_enable,
  input  logic [N_CH-1:0]           ch_auto_dn,
  input  logic [N_CH-1:0]           ch_sat,
  input  logic [N_CH-1:0]           ch_up,
  input  logic [N_CH-1:0]           ch_down,
  input  logic [N_CH*DIV_WIDTH-1:0] div_reload,
  input  logic [N_CH*WIDTH-1:0]     cmp_val,
  input  logic                      snap,
  output logic [N_CH*WIDTH-1:0]     count,
  output logic [N_CH*WIDTH-1:0]     snap_count,
  output logic [N_CH-1:0]           eq_zero,
  output logic [N_CH-1:0]           eq_cmp,
  output logic [N_CH-1:0]           tc_up,
  output logic [N_CH-1:0]           tc_dn
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DIV_WIDTH-1:0] div;
    logic                 tick;
    logic [WIDTH-1:0]     cnt;
    logic [WIDTH-1:0]     cnt_next;
    logic                 step_up;
    logic                 step_dn;
    logic                 tcu_next;
    logic                 tcd_next;
    logic                 tcu_r;
    logic                 tcd_r;
    logic                 eqz_r;
    logic                 eqc_r;

    // Priority: clear > manual up > manual down > enabled auto tick.
    always_comb begin
      step_up  = ch_up[i] | (~ch_down[i] & tick & ch_enable[i] & ~ch_auto_dn[i]);
      step_dn  = ~ch_up[i] & (ch_down[i] | (tick & ch_enable[i] & ch_auto_dn[i]));
      cnt_next = cnt;
      tcu_next = 1'b0;
      tcd_next = 1'b0;
      if (ch_clear[i]) begin
        cnt_next = '0;
      end else if (step_up) begin
        if (cnt == CNT_MAX) begin
          tcu_next = 1'b1;
          cnt_next = ch_sat[i] ? CNT_MAX : '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end else if (step_dn) begin
        if (cnt == '0) begin
          tcd_next = 1'b1;
          cnt_next = ch_sat[i] ? '0 : CNT_MAX;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
    end

    always_ff @(posedge sys_clk) begin
      if (reset) begin
        div   <= '0;
        tick  <= 1'b0;
        cnt   <= '0;
        tcu_r <= 1'b0;
        tcd_r <= 1'b0;
        eqz_r <= 1'b0;
        eqc_r <= 1'b0;
      end else begin
        if (div == '0) begin
          div  <= div_reload[i*DIV_WIDTH +: DIV_WIDTH];
          tick <= 1'b1;
        end else begin
          div  <= div - 1'b1;
          tick <= 1'b0;
        end
        cnt   <= cnt_next;
        tcu_r <= tcu_next;
        tcd_r <= tcd_next;
        eqz_r <= (cnt == '0);
        eqc_r <= (cnt == cmp_val[i*WIDTH +: WIDTH]);
      end
    end

    assign count[i*WIDTH +: WIDTH] = cnt;
    assign tc_up[i]   = tcu_r;
    assign tc_dn[i]   = tcd_r;
    assign eq_zero[i] = eqz_r;
    assign eq_cmp[i]  = eqc_r;
  end

`ifdef COUNTER_BANK_SNAPSHOT_EN
  // Captures the pre-update counts of all channels on the same edge.
  logic [N_CH*WIDTH-1:0] snap_r;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      snap_r <= '0;
    end else if (snap) begin
      snap_r <= count;
    end
  end

  assign snap_count = snap_r;
`else
  logic unused_snap;
  assign unused_snap = snap;
  assign snap_count  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: integer-level model compared every
// cycle, plus directed literal checks from the test plan.
`timescale 1ns/1ps
`default_nettype none

module tb_counter_bank;
  localparam int N    = 2;
  localparam int W    = 8;
  localparam int D    = 24;
  localparam int MAXV = 255;

  logic           sys_clk = 1'b0;
  logic           reset;
  logic [N-1:0]   ch_clear, ch_enable, ch_auto_dn, ch_sat, ch_up, ch_down;
  logic [N*D-1:0] div_reload;
  logic [N*W-1:0] cmp_val;
  logic           snap;
  logic [N*W-1:0] count, snap_count;
  logic [N-1:0]   eq_zero, eq_cmp, tc_up, tc_dn;

  int n_vec = 0;
  int n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  counter_bank #(.N_CH(N), .WIDTH(W), .DIV_WIDTH(D)) dut (
    .sys_clk(sys_clk), .reset(reset), .ch_clear(ch_clear), .ch_enable(ch_enable),
    .ch_auto_dn(ch_auto_dn), .ch_sat(ch_sat), .ch_up(ch_up), .ch_down(ch_down),
    .div_reload(div_reload), .cmp_val(cmp_val), .snap(snap), .count(count),
    .snap_count(snap_count), .eq_zero(eq_zero), .eq_cmp(eq_cmp),
    .tc_up(tc_up), .tc_dn(tc_dn)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: plain integers, updated at each rising edge.
  int m_cnt[N]  = '{default: 0};
  int m_div[N]  = '{default: 0};
  int m_snap[N] = '{default: 0};
  int old_c[N]  = '{default: 0};
  bit m_tick[N] = '{default: 0};
  bit m_eqz[N]  = '{default: 0};
  bit m_eqc[N]  = '{default: 0};
  bit m_tcu[N]  = '{default: 0};
  bit m_tcd[N]  = '{default: 0};
  bit up_s, dn_s;
  bit started = 0;

  always @(posedge sys_clk) begin
    started = 1;
    if (reset) begin
      for (int c = 0; c < N; c++) begin
        m_cnt[c] = 0; m_div[c] = 0; m_snap[c] = 0; m_tick[c] = 0;
        m_eqz[c] = 0; m_eqc[c] = 0; m_tcu[c] = 0; m_tcd[c] = 0;
      end
    end else begin
      for (int c = 0; c < N; c++) old_c[c] = m_cnt[c];
      for (int c = 0; c < N; c++) begin
        m_eqz[c] = (old_c[c] == 0);
        m_eqc[c] = (old_c[c] == int'(cmp_val[c*W +: W]));
        m_tcu[c] = 0;
        m_tcd[c] = 0;
        up_s = ch_up[c] || (!ch_down[c] && m_tick[c] && ch_enable[c] && !ch_auto_dn[c]);
        dn_s = !up_s && (ch_down[c] || (m_tick[c] && ch_enable[c] && ch_auto_dn[c]));
        if (ch_clear[c]) m_cnt[c] = 0;
        else if (up_s) begin
          if (old_c[c] == MAXV) begin
            m_tcu[c] = 1;
            m_cnt[c] = ch_sat[c] ? MAXV : 0;
          end else m_cnt[c] = old_c[c] + 1;
        end else if (dn_s) begin
          if (old_c[c] == 0) begin
            m_tcd[c] = 1;
            m_cnt[c] = ch_sat[c] ? 0 : MAXV;
          end else m_cnt[c] = old_c[c] - 1;
        end
        if (m_div[c] == 0) begin
          m_div[c]  = int'(div_reload[c*D +: D]);
          m_tick[c] = 1;
        end else begin
          m_div[c]  = m_div[c] - 1;
          m_tick[c] = 0;
        end
`ifdef COUNTER_BANK_SNAPSHOT_EN
        if (snap) m_snap[c] = old_c[c];
`endif
      end
    end
  end

  always @(negedge sys_clk) begin
    if (started) begin
      for (int c = 0; c < N; c++) begin
        chk($sformatf("count[%0d]", c),      32'(count[c*W +: W]),      m_cnt[c]);
        chk($sformatf("snap_count[%0d]", c), 32'(snap_count[c*W +: W]), m_snap[c]);
        chk($sformatf("eq_zero[%0d]", c),    32'(eq_zero[c]),           32'(m_eqz[c]));
        chk($sformatf("eq_cmp[%0d]", c),     32'(eq_cmp[c]),            32'(m_eqc[c]));
        chk($sformatf("tc_up[%0d]", c),      32'(tc_up[c]),             32'(m_tcu[c]));
        chk($sformatf("tc_dn[%0d]", c),      32'(tc_dn[c]),             32'(m_tcd[c]));
      end
    end
  end

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  initial begin
    reset      = 1'b1;
    ch_clear   = '0;
    ch_enable  = 2'b01;
    ch_auto_dn = '0;
    ch_sat     = '0;
    ch_up      = '0;
    ch_down    = '0;
    snap       = 1'b0;
    div_reload = {24'd0, 24'd3};
    cmp_val    = {8'h00, 8'h05};

    adv(2);
    chk("rst_count", 32'(count), 0);
    chk("rst_eq_zero", 32'(eq_zero), 0);
    reset = 1'b0;

    // Auto up, prescaler period 4, compare at 5.
    adv(1);  chk("eqz_after_rel", 32'(eq_zero[0]), 1);
    adv(1);  chk("first_step", 32'(count[7:0]), 1);
    adv(1);  chk("eqz_cleared", 32'(eq_zero[0]), 0);
    adv(3);  chk("second_step", 32'(count[7:0]), 2);
    adv(12); chk("cnt5", 32'(count[7:0]), 5);
             chk("eqc_lag", 32'(eq_cmp[0]), 0);
    adv(1);  chk("eqc_hit", 32'(eq_cmp[0]), 1);
    adv(3);  chk("cnt6", 32'(count[7:0]), 6);
    adv(1);  chk("eqc_drop", 32'(eq_cmp[0]), 0);

    // Disabled auto, manual up still works.
    ch_enable[0] = 1'b0; ch_up[0] = 1'b1;
    adv(1);  chk("manual_up", 32'(count[7:0]), 7);
    ch_up[0] = 1'b0;
    adv(6);  chk("no_auto", 32'(count[7:0]), 7);

    // Wrap mode on channel 1.
    ch_down[1] = 1'b1;
    adv(1);  chk("wrap_dn", 32'(count[15:8]), 8'hFF); chk("tc_dn_p", 32'(tc_dn[1]), 1);
    ch_down[1] = 1'b0;
    adv(1);  chk("tc_dn_end", 32'(tc_dn[1]), 0);
    ch_up[1] = 1'b1;
    adv(1);  chk("wrap_up", 32'(count[15:8]), 0); chk("tc_up_p", 32'(tc_up[1]), 1);
    ch_up[1] = 1'b0;
    adv(1);  chk("tc_up_end", 32'(tc_up[1]), 0); chk("eqz_wrap", 32'(eq_zero[1]), 1);

    // Saturate mode.
    ch_sat[1] = 1'b1; ch_down[1] = 1'b1;
    adv(1);  chk("sat_dn", 32'(count[15:8]), 0); chk("sat_tc_dn", 32'(tc_dn[1]), 1);
    ch_sat[1] = 1'b0;
    adv(1);  chk("to_max", 32'(count[15:8]), 8'hFF);
    ch_down[1] = 1'b0; ch_sat[1] = 1'b1; ch_up[1] = 1'b1;
    adv(1);  chk("sat_up", 32'(count[15:8]), 8'hFF); chk("sat_tc_up", 32'(tc_up[1]), 1);
    ch_up[1] = 1'b0; ch_sat[1] = 1'b0;

    // Clear, count to 0x10, then priority cases.
    ch_clear[1] = 1'b1;
    adv(1);  chk("clear", 32'(count[15:8]), 0);
    ch_clear[1] = 1'b0; ch_enable[1] = 1'b1;
    adv(16);
    ch_enable[1] = 1'b0;
    chk("cnt_0x10", 32'(count[15:8]), 8'h10);
    ch_up[1] = 1'b1; ch_down[1] = 1'b1;
    adv(1);  chk("up_wins", 32'(count[15:8]), 8'h11);
    ch_down[1] = 1'b0; ch_clear[1] = 1'b1;
    adv(1);  chk("clr_wins", 32'(count[15:8]), 0); chk("clr_no_tc", 32'(tc_up[1]), 0);
    ch_clear[1] = 1'b0; ch_up[1] = 1'b0;

    // Reload change mid-count, auto down on channel 0.
    div_reload[23:0] = 24'd2; ch_auto_dn[0] = 1'b1; ch_enable[0] = 1'b1;
    adv(20);
    ch_enable[0] = 1'b0; ch_auto_dn[0] = 1'b0;

    // Snapshot with 0x12 / 0x34.
    ch_clear = 2'b11; div_reload = '0;
    adv(8);
    ch_clear = 2'b00; ch_enable = 2'b11;
    adv(18);
    ch_enable = 2'b10;
    adv(34);
    chk("pre_snap0", 32'(count[7:0]), 8'h12);
    chk("pre_snap1", 32'(count[15:8]), 8'h34);
    ch_enable = 2'b11; snap = 1'b1;
    adv(1);
    snap = 1'b0; ch_enable = 2'b00;
    chk("post_step", 32'(count), 16'h3513);
`ifdef COUNTER_BANK_SNAPSHOT_EN
    chk("snap_val", 32'(snap_count), 16'h3412);
`else
    chk("snap_off", 32'(snap_count), 0);
`endif

    // Reset mid-operation drops pending pulses.
    ch_up = 2'b11; reset = 1'b1;
    adv(1);
    chk("mid_rst_cnt", 32'(count), 0);
    chk("mid_rst_tc", 32'(tc_up), 0);
    ch_up = 2'b00; reset = 1'b0;
    adv(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/counter_bank.md
# counter_bank

Parametrised multi-channel event/timer counter bank, successor to the two-counter sample logic. Each of N_CH channels has its own prescaler, up/down manual steps, auto-count direction, wrap or saturate mode, compare match and terminal-count event flags. It sits on the sys_clk domain between FrontPanel wire/trigger endpoints (controls in, counts and flags out) and user logic such as LEDs.

## Interface
- N_CH, 2: number of independent channels (1..16).
- WIDTH, 8: counter width per channel (2..32).
- DIV_WIDTH, 24: prescaler width per channel.
- sys_clk  in  1  sole clock; all logic is posedge sys_clk.
- reset  in  1  synchronous, active-high; clears the whole bank.
- ch_clear  in  N_CH  level; holds the channel count at 0.
- ch_enable  in  N_CH  level; gates auto-counting only.
- ch_auto_dn  in  N_CH  auto-count direction: 0 = up, 1 = down.
- ch_sat  in  N_CH  0 = wrap modulo 2^WIDTH, 1 = saturate at 0 / max.
- ch_up  in  N_CH  single-cycle pulse; one up step.
- ch_down  in  N_CH  single-cycle pulse; one down step.
- div_reload  in  N_CH*DIV_WIDTH  prescaler reload value, channel i at [i*DIV_WIDTH +: DIV_WIDTH].
- cmp_val  in  N_CH*WIDTH  compare value per channel.
- snap  in  1  capture request for all channels (see Configuration).
- count  out  N_CH*WIDTH  live counts, channel i at [i*WIDTH +: WIDTH].
- snap_count  out  N_CH*WIDTH  captured counts.
- eq_zero  out  N_CH  registered: count == 0.
- eq_cmp  out  N_CH  registered: count == cmp_val.
- tc_up  out  N_CH  one-cycle pulse: up step attempted at max.
- tc_dn  out  N_CH  one-cycle pulse: down step attempted at 0.

## Operation
- Prescaler per channel: div decrements each cycle; when div == 0 it reloads div_reload and registers tick = 1 for one cycle. Tick period = div_reload + 1 cycles; div_reload = 0 gives tick every cycle.
- Step selection per channel, priority high to low: ch_clear (count <= 0), ch_up, ch_down, (tick & ch_enable) in direction ch_auto_dn. Simultaneous ch_up and ch_down: up wins, down is dropped. Manual pulses ignore ch_enable.
- Up step at max (2^WIDTH-1): wrap mode -> 0; saturate mode -> hold max; tc_up pulses either way.
- Down step at 0: wrap mode -> max; saturate mode -> hold 0; tc_dn pulses either way.
- ch_clear never raises tc_up/tc_dn.
- eq_zero / eq_cmp compare the current count register and update every cycle; changing cmp_val is reflected one cycle later.
- Channels are fully independent; no cross-channel carry.

## Timing
- Reset (held one or more cycles): count = 0, div = 0, tick = 0, eq_zero = 0, eq_cmp = 0, tc_up = 0, tc_dn = 0, snap_count = 0. First tick is one cycle after reset drops, next ones every div_reload + 1 cycles.
- Step pulse on cycle n -> count updated at edge n+1; tc_up/tc_dn high during cycle n+1 only (same edge as count).
- eq_zero / eq_cmp lag count by exactly one cycle.
- div_reload change mid-count takes effect at the next reload; the running countdown is not disturbed.
- Reset mid-operation overrides every input that cycle; pending pulses are lost.

## Configuration
- COUNTER_BANK_SNAPSHOT_EN defined: snap high on cycle n captures all N_CH counts as present at edge n (pre-update) into snap_count at edge n+1, atomically across channels; snap_count holds until next snap or reset.
- Not defined: snapshot registers are not built; snap ignored; snap_count tied to 0.

## Test plan
- Reset, WIDTH=8, div_reload=3, enable=1, auto up -> count increments every 4 cycles; first increment 2 cycles after reset release (tick then step); eq_zero=1 one cycle after reset release, 0 after first step.
- Wrap mode, count 0xFF, ch_up pulse -> count 0x00, tc_up one cycle, eq_zero next cycle.
- Saturate mode, count 0x00, ch_down pulse -> count stays 0x00, tc_dn one cycle; count 0xFF, ch_up -> stays 0xFF, tc_up.
- ch_up and ch_down same cycle at count 0x10 -> 0x11; ch_clear with ch_up -> 0x00, no tc pulse.
- cmp_val=0x05, auto up from 0 -> eq_cmp high exactly one cycle after count reaches 0x05; ch_enable=0 stops auto steps while ch_up still steps.
- With COUNTER_BANK_SNAPSHOT_EN, N_CH=2 counts 0x12/0x34 with auto steps on snap cycle -> snap_count = {0x34,0x12} (pre-step); without macro -> snap_count = 0.
